// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divider front end: divider register map, controller
// states and the quotient returned for a divide-by-zero.
package div_ctrl_pkg;

    localparam logic [7:0] REG_INFO      = 8'h00;
    localparam logic [7:0] REG_DIVISOR   = 8'h04;
    localparam logic [7:0] REG_DIVIDEND  = 8'h08;
    localparam logic [7:0] REG_QUOTIENT  = 8'h0C;
    localparam logic [7:0] REG_REMAINDER = 8'h10;

    localparam logic [31:0] DBZ_QUOTIENT = 32'hFFFFFFFF;

    typedef enum logic [3:0] {
        IDLE,
        GRANT,
        WR_DIVISOR,
        WR_DIVIDEND,
        WAIT,
        POLL,
        RD_QUO,
        RD_REM,
        RESP
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first set request found from pointer+1
// upward, wrapping, as both a one-hot vector and an index.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         i_req,
    input  logic [$clog2(N_REQ)-1:0] i_pointer,
    output logic [N_REQ-1:0]         o_grant,
    output logic [$clog2(N_REQ)-1:0] o_index
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] w_scanIdx;

    // Scanning from the farthest candidate to the nearest lets the nearest hit win.
    always_comb begin
        o_grant   = '0;
        o_index   = '0;
        w_scanIdx = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_scanIdx = IDX_W'((int'(i_pointer) + k) % N_REQ);
            if (i_req[w_scanIdx]) begin
                o_grant            = '0;
                o_grant[w_scanIdx] = 1'b1;
                o_index            = w_scanIdx;
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin front end sharing one seq_divider among N_REQ clients; each grant runs
// the divider register sequence and returns the result on a single response bus.
module div_arbiter
    import div_ctrl_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [32*N_REQ-1:0]      req_dividend,
    input  logic [32*N_REQ-1:0]      req_divisor,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [$clog2(N_REQ)-1:0] resp_id,
    output logic [31:0]              resp_quotient,
    output logic [31:0]              resp_remainder,
    output logic                     resp_dbz,
    output logic                     resp_timeout,
    output logic [7:0]               div_address,
    output logic [31:0]              div_write_data,
    output logic                     div_we,
    output logic                     div_re,
    input  logic [31:0]              div_read_data
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int PCNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    state_t            r_state, w_nextState;
    logic [IDX_W-1:0]  r_grantIdx, r_pointer, w_arbIdx;
    logic [N_REQ-1:0]  r_reqReady, w_arbOneHot;
    logic [31:0]       r_dividend, w_selDividend, w_selDivisor;
    logic [31:0]       w_dividendArr [N_REQ];
    logic [31:0]       w_divisorArr [N_REQ];
    logic [PCNT_W-1:0] r_pollCnt;
    logic              w_pollExpired;
    logic              r_respValid, r_respDbz, r_respTimeout;
    logic [31:0]       r_respQuotient, r_respRemainder;
    logic [7:0]        r_divAddress, w_busAddress;
    logic [31:0]       r_divWriteData, w_busWriteData;
    logic              r_divWe, r_divRe, w_busWe, w_busRe;

    rr_arbiter #(.N_REQ(N_REQ)) u_arbiter (
        .i_req     (req_valid),
        .i_pointer (r_pointer),
        .o_grant   (w_arbOneHot),
        .o_index   (w_arbIdx)
    );

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_dividendArr[i] = req_dividend[32*i +: 32];
            w_divisorArr[i]  = req_divisor[32*i +: 32];
        end
    end

    assign w_selDividend = w_dividendArr[r_grantIdx];
    assign w_selDivisor  = w_divisorArr[r_grantIdx];
    assign w_pollExpired = (r_pollCnt == PCNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:        if (|req_valid) w_nextState = GRANT;
            GRANT:       w_nextState = (w_selDivisor == '0) ? RESP : WR_DIVISOR;
            WR_DIVISOR:  w_nextState = WR_DIVIDEND;
            WR_DIVIDEND: w_nextState = WAIT;
            WAIT:        w_nextState = POLL;
            POLL: begin
                if (div_read_data[0])   w_nextState = RD_QUO;
                else if (w_pollExpired) w_nextState = RESP;
            end
            RD_QUO:      w_nextState = RD_REM;
            RD_REM:      w_nextState = RESP;
            RESP:        if (resp_ready) w_nextState = IDLE;
            default:     w_nextState = IDLE;
        endcase
    end

    // Divider port values are derived from the state being entered so the port is
    // driven straight from flops during that state.
    always_comb begin
        w_busAddress   = '0;
        w_busWriteData = '0;
        w_busWe        = 1'b0;
        w_busRe        = 1'b0;
        case (w_nextState)
            WR_DIVISOR: begin
                w_busAddress   = REG_DIVISOR;
                w_busWriteData = w_selDivisor;
                w_busWe        = 1'b1;
            end
            WR_DIVIDEND: begin
                w_busAddress   = REG_DIVIDEND;
                w_busWriteData = r_dividend;
                w_busWe        = 1'b1;
            end
            POLL: begin
                w_busAddress = REG_INFO;
                w_busRe      = 1'b1;
            end
            RD_QUO: begin
                w_busAddress = REG_QUOTIENT;
                w_busRe      = 1'b1;
            end
            RD_REM: begin
                w_busAddress = REG_REMAINDER;
                w_busRe      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_pointer       <= IDX_W'(N_REQ - 1);
            r_grantIdx      <= '0;
            r_reqReady      <= '0;
            r_dividend      <= '0;
            r_pollCnt       <= '0;
            r_respValid     <= 1'b0;
            r_respDbz       <= 1'b0;
            r_respTimeout   <= 1'b0;
            r_respQuotient  <= '0;
            r_respRemainder <= '0;
            r_divAddress    <= '0;
            r_divWriteData  <= '0;
            r_divWe         <= 1'b0;
            r_divRe         <= 1'b0;
        end else begin
            r_state        <= w_nextState;
            r_reqReady     <= '0;
            r_respValid    <= (w_nextState == RESP);
            r_divAddress   <= w_busAddress;
            r_divWriteData <= w_busWriteData;
            r_divWe        <= w_busWe;
            r_divRe        <= w_busRe;
            case (r_state)
                IDLE: begin
                    if (|req_valid) begin
                        r_grantIdx <= w_arbIdx;
                        r_reqReady <= w_arbOneHot;
                    end
                end
                GRANT: begin
                    r_pointer       <= r_grantIdx;
                    r_dividend      <= w_selDividend;
                    r_pollCnt       <= '0;
                    r_respTimeout   <= 1'b0;
                    r_respDbz       <= (w_selDivisor == '0);
                    r_respQuotient  <= (w_selDivisor == '0) ? DBZ_QUOTIENT : '0;
                    r_respRemainder <= (w_selDivisor == '0) ? w_selDividend : '0;
                end
                POLL: begin
                    if (!div_read_data[0]) begin
                        r_pollCnt <= r_pollCnt + 1'b1;
                        if (w_pollExpired) begin
                            r_respTimeout   <= 1'b1;
                            r_respQuotient  <= '0;
                            r_respRemainder <= '0;
                        end
                    end
                end
                RD_QUO:  r_respQuotient  <= div_read_data;
                RD_REM:  r_respRemainder <= div_read_data;
                default: ;
            endcase
        end
    end

    assign req_ready      = r_reqReady;
    assign resp_valid     = r_respValid;
    assign resp_id        = r_grantIdx;
    assign resp_quotient  = r_respQuotient;
    assign resp_remainder = r_respRemainder;
    assign resp_dbz       = r_respDbz;
    assign resp_timeout   = r_respTimeout;
    assign div_address    = r_divAddress;
    assign div_write_data = r_divWriteData;
    assign div_we         = r_divWe;
    assign div_re         = r_divRe;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: a seq_divider-like peripheral model with a fixed busy time,
// and a reference computed from round-robin order and plain integer division.
module tb_div_arbiter;

    localparam int N   = 4;
    localparam int TMO = 64;
    localparam int B   = 33;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [32*N-1:0]   req_dividend;
    logic [32*N-1:0]   req_divisor;
    logic [N-1:0]      req_ready;
    logic              resp_valid;
    logic              resp_ready;
    logic [1:0]        resp_id;
    logic [31:0]       resp_quotient;
    logic [31:0]       resp_remainder;
    logic              resp_dbz;
    logic              resp_timeout;
    logic [7:0]        div_address;
    logic [31:0]       div_write_data;
    logic              div_we;
    logic              div_re;
    logic [31:0]       div_read_data;

    int checks   = 0;
    int failures = 0;

    div_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_dividend   (req_dividend),
        .req_divisor    (req_divisor),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_id        (resp_id),
        .resp_quotient  (resp_quotient),
        .resp_remainder (resp_remainder),
        .resp_dbz       (resp_dbz),
        .resp_timeout   (resp_timeout),
        .div_address    (div_address),
        .div_write_data (div_write_data),
        .div_we         (div_we),
        .div_re         (div_re),
        .div_read_data  (div_read_data)
    );

    always #5 clk = ~clk;

    // Divider peripheral model: reports ready again B cycles after the start write.
    logic [31:0] mDivisor = '0, mQuo = '0, mRem = '0;
    int          busyCnt = 0;
    bit          neverReady = 1'b0;
    int          weCount = 0, reCount = 0, infoReads = 0, pulseCount = 0;
    logic [39:0] busLog [$];

    always @(posedge clk) begin
        pulseCount <= pulseCount + $countones(req_ready);
        if (div_re) begin
            reCount <= reCount + 1;
            if (div_address == 8'h00) infoReads <= infoReads + 1;
        end
        if (div_we) begin
            weCount <= weCount + 1;
            busLog.push_back({div_address, div_write_data});
            if (div_address == 8'h04) mDivisor <= div_write_data;
            if (div_address == 8'h08) begin
                mQuo    <= (mDivisor == 0) ? 32'hFFFFFFFF : div_write_data / mDivisor;
                mRem    <= (mDivisor == 0) ? div_write_data : div_write_data % mDivisor;
                busyCnt <= B;
            end
        end else if (busyCnt > 0) begin
            busyCnt <= busyCnt - 1;
        end
    end

    always_comb begin
        case (div_address)
            8'h00:   div_read_data = {31'b0, (busyCnt == 0) && !neverReady};
            8'h0C:   div_read_data = mQuo;
            8'h10:   div_read_data = mRem;
            default: div_read_data = '0;
        endcase
    end

    function automatic int nextGrant(input logic [N-1:0] v, input int ptr);
        for (int k = 1; k <= N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [31:0] randDivisor();
        case ($urandom_range(0, 3))
            0:       return 32'd0;
            1:       return 32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic applyReset();
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input int idx, input logic [31:0] a, input logic [31:0] b);
        req_dividend[idx*32 +: 32] = a;
        req_divisor[idx*32 +: 32]  = b;
        req_valid[idx]             = 1'b1;
    endtask

    task automatic waitGrant(output int idx, output bit ok);
        ok  = 1'b0;
        idx = -1;
        for (int c = 0; c < 300; c++) begin
            if (req_ready != '0) begin
                ok = 1'b1;
                for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL grant_wait: got no req_ready, expected a grant within 300 cycles");
        end
    endtask

    task automatic waitResp(output int lat, output bit ok);
        lat = 0;
        while (!resp_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        ok = resp_valid;
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL resp_wait: got no resp_valid, expected one within 300 cycles");
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        resp_ready   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_dbz, resp_timeout, div_we, div_re} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0",
                     {req_ready, resp_valid, resp_dbz, resp_timeout, div_we, div_re});
        end
        checks++;
        if ({resp_id, resp_quotient, resp_remainder} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_resp: got %h expected 0", {resp_id, resp_quotient, resp_remainder});
        end
        checks++;
        if ({div_address, div_write_data} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_bus: got %h expected 0", {div_address, div_write_data});
        end
        rst = 1'b0;
    endtask

    task automatic test_single_divide();
        int g, lat, pulses0;
        bit ok;
        pulses0 = pulseCount;
        busLog.delete();
        applyStimulus(0, 32'd100, 32'd7);
        waitGrant(g, ok);
        req_valid[0] = 1'b0;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL single_grant: got %b expected 0001", req_ready);
        end
        waitResp(lat, ok);
        checks++;
        if (lat != 39) begin
            failures++;
            $display("[TB] FAIL single_latency: got %0d expected 39", lat);
        end
        checks++;
        if ({resp_id, resp_quotient, resp_remainder, resp_dbz, resp_timeout} !== {2'd0, 32'd14, 32'd2, 2'b00}) begin
            failures++;
            $display("[TB] FAIL single_result: got id=%0d q=%0d r=%0d dbz=%b tmo=%b expected id=0 q=14 r=2 dbz=0 tmo=0",
                     resp_id, resp_quotient, resp_remainder, resp_dbz, resp_timeout);
        end
        checks++;
        if (busLog.size() != 2 || busLog[0] !== {8'h04, 32'd7} || busLog[1] !== {8'h08, 32'd100}) begin
            failures++;
            $display("[TB] FAIL single_bus: got %0d writes first=%h expected 2 writes 04:7 then 08:100",
                     busLog.size(), (busLog.size() > 0) ? busLog[0] : 40'h0);
        end
        checks++;
        if (pulseCount - pulses0 != 1) begin
            failures++;
            $display("[TB] FAIL single_pulses: got %0d req_ready pulses expected 1", pulseCount - pulses0);
        end
        @(negedge clk);
    endtask

    task automatic test_divide_by_zero();
        int g, lat, we0, re0;
        bit ok;
        we0 = weCount;
        re0 = reCount;
        applyStimulus(2, 32'd55, 32'd0);
        waitGrant(g, ok);
        req_valid[2] = 1'b0;
        checks++;
        if (g != 2) begin
            failures++;
            $display("[TB] FAIL dbz_grant: got %0d expected 2", g);
        end
        waitResp(lat, ok);
        checks++;
        if (lat != 1) begin
            failures++;
            $display("[TB] FAIL dbz_latency: got %0d expected 1", lat);
        end
        checks++;
        if ({resp_id, resp_quotient, resp_remainder, resp_dbz, resp_timeout} !== {2'd2, 32'hFFFFFFFF, 32'd55, 2'b10}) begin
            failures++;
            $display("[TB] FAIL dbz_result: got id=%0d q=%h r=%0d dbz=%b tmo=%b expected id=2 q=ffffffff r=55 dbz=1 tmo=0",
                     resp_id, resp_quotient, resp_remainder, resp_dbz, resp_timeout);
        end
        @(negedge clk);
        checks++;
        if (weCount != we0 || reCount != re0) begin
            failures++;
            $display("[TB] FAIL dbz_bus: got %0d writes %0d reads expected 0 and 0", weCount - we0, reCount - re0);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] opA [N];
        logic [31:0] opB [N];
        logic [31:0] a, b, expQ, expR;
        int g, lat, ptr;
        bit ok;
        applyReset();
        ptr = N - 1;
        for (int i = 0; i < N; i++) begin
            opA[i] = $urandom;
            opB[i] = randDivisor();
            applyStimulus(i, opA[i], opB[i]);
        end
        for (int n = 0; n < 8; n++) begin
            waitGrant(g, ok);
            if (!ok) break;
            checks++;
            if (g != nextGrant('1, ptr)) begin
                failures++;
                $display("[TB] FAIL rr_order: got %0d expected %0d", g, nextGrant('1, ptr));
            end
            ptr  = g;
            a    = opA[g];
            b    = opB[g];
            expQ = (b == 0) ? 32'hFFFFFFFF : a / b;
            expR = (b == 0) ? a : a % b;
            @(negedge clk);
            opA[g] = $urandom;
            opB[g] = randDivisor();
            applyStimulus(g, opA[g], opB[g]);
            waitResp(lat, ok);
            checks++;
            if ({resp_id, resp_quotient, resp_remainder, resp_dbz, resp_timeout} !== {2'(g), expQ, expR, (b == 0), 1'b0}) begin
                failures++;
                $display("[TB] FAIL rr_result: got id=%0d q=%h r=%h dbz=%b expected id=%0d q=%h r=%h dbz=%b",
                         resp_id, resp_quotient, resp_remainder, resp_dbz, g, expQ, expR, (b == 0));
            end
            if (n == 7) req_valid = '0;
        end
        @(negedge clk);
    endtask

    task automatic test_back_pressure();
        logic [31:0] a, b, a3, b3, a0, b0;
        logic [72:0] expVec;
        int g, lat;
        bit ok;
        applyReset();
        a  = $urandom;
        b  = 32'($urandom_range(1, 1000));
        a3 = $urandom;
        b3 = 32'($urandom_range(1, 1000));
        a0 = $urandom;
        b0 = 32'($urandom_range(1, 1000));
        resp_ready = 1'b0;
        applyStimulus(1, a, b);
        waitGrant(g, ok);
        req_valid[1] = 1'b0;
        checks++;
        if (g != nextGrant(4'b0010, N - 1)) begin
            failures++;
            $display("[TB] FAIL bp_grant: got %0d expected 1", g);
        end
        @(negedge clk);
        applyStimulus(3, a3, b3);
        applyStimulus(0, a0, b0);
        waitResp(lat, ok);
        expVec = {1'b1, 4'b0000, 2'd1, a / b, a % b, 2'b00};
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({resp_valid, req_ready, resp_id, resp_quotient, resp_remainder, resp_dbz, resp_timeout} !== expVec) begin
                failures++;
                $display("[TB] FAIL bp_hold: cycle %0d got %h expected %h", c,
                         {resp_valid, req_ready, resp_id, resp_quotient, resp_remainder, resp_dbz, resp_timeout}, expVec);
            end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({resp_valid, req_ready} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL bp_release: got %b expected 00000", {resp_valid, req_ready});
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 4'(1 << nextGrant(4'b1001, 1))) begin
            failures++;
            $display("[TB] FAIL bp_next_grant: got %b expected 1000", req_ready);
        end
        req_valid[3] = 1'b0;
        waitResp(lat, ok);
        checks++;
        if ({resp_id, resp_quotient, resp_remainder} !== {2'd3, a3 / b3, a3 % b3}) begin
            failures++;
            $display("[TB] FAIL bp_req3: got id=%0d q=%h r=%h expected id=3 q=%h r=%h",
                     resp_id, resp_quotient, resp_remainder, a3 / b3, a3 % b3);
        end
        waitGrant(g, ok);
        req_valid[0] = 1'b0;
        checks++;
        if (g != 0) begin
            failures++;
            $display("[TB] FAIL bp_wrap_grant: got %0d expected 0", g);
        end
        waitResp(lat, ok);
        checks++;
        if ({resp_id, resp_quotient, resp_remainder} !== {2'd0, a0 / b0, a0 % b0}) begin
            failures++;
            $display("[TB] FAIL bp_req0: got id=%0d q=%h r=%h expected id=0 q=%h r=%h",
                     resp_id, resp_quotient, resp_remainder, a0 / b0, a0 % b0);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        logic [31:0] a, b;
        int g, lat, info0;
        bit ok;
        applyReset();
        neverReady = 1'b1;
        applyStimulus(0, $urandom, 32'($urandom_range(1, 500)));
        waitGrant(g, ok);
        req_valid[0] = 1'b0;
        info0 = infoReads;
        waitResp(lat, ok);
        checks++;
        if (lat != TMO + 4) begin
            failures++;
            $display("[TB] FAIL tmo_latency: got %0d expected %0d", lat, TMO + 4);
        end
        checks++;
        if ({resp_quotient, resp_remainder, resp_dbz, resp_timeout} !== {64'd0, 2'b01}) begin
            failures++;
            $display("[TB] FAIL tmo_result: got q=%h r=%h dbz=%b tmo=%b expected q=0 r=0 dbz=0 tmo=1",
                     resp_quotient, resp_remainder, resp_dbz, resp_timeout);
        end
        checks++;
        if (infoReads - info0 != TMO) begin
            failures++;
            $display("[TB] FAIL tmo_polls: got %0d INFO reads expected %0d", infoReads - info0, TMO);
        end
        neverReady = 1'b0;
        @(negedge clk);
        a = $urandom;
        b = 32'($urandom_range(1, 500));
        applyStimulus(1, a, b);
        waitGrant(g, ok);
        req_valid[1] = 1'b0;
        waitResp(lat, ok);
        checks++;
        if ({lat[7:0], resp_id, resp_quotient, resp_remainder, resp_timeout} !== {8'd39, 2'd1, a / b, a % b, 1'b0}) begin
            failures++;
            $display("[TB] FAIL tmo_recover: got lat=%0d id=%0d q=%h r=%h tmo=%b expected lat=39 id=1 q=%h r=%h tmo=0",
                     lat, resp_id, resp_quotient, resp_remainder, resp_timeout, a / b, a % b);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_poll();
        int g, lat;
        bit ok;
        applyStimulus(0, $urandom, 32'($urandom_range(1, 500)));
        waitGrant(g, ok);
        req_valid[0] = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_id, resp_quotient, resp_remainder, resp_dbz, resp_timeout,
             div_address, div_write_data, div_we, div_re} !== '0) begin
            failures++;
            $display("[TB] FAIL midreset_outputs: got req_ready=%b resp_valid=%b addr=%h we=%b re=%b expected all 0",
                     req_ready, resp_valid, div_address, div_we, div_re);
        end
        rst = 1'b0;
        applyStimulus(2, 32'hFFFFFFFF, 32'd16);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL midreset_grant: got %b expected 0100", req_ready);
        end
        req_valid[2] = 1'b0;
        waitResp(lat, ok);
        checks++;
        if ({resp_id, resp_quotient, resp_remainder, resp_dbz, resp_timeout} !== {2'd2, 32'h0FFFFFFF, 32'd15, 2'b00}) begin
            failures++;
            $display("[TB] FAIL midreset_result: got id=%0d q=%h r=%0d expected id=2 q=0fffffff r=15",
                     resp_id, resp_quotient, resp_remainder);
        end
        @(negedge clk);
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        resp_ready   = 1'b1;
        test_reset();
        test_single_divide();
        test_divide_by_zero();
        test_round_robin();
        test_back_pressure();
        test_timeout();
        test_reset_mid_poll();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares one seq_divider peripheral among N_REQ requesters using round-robin arbitration.
- Each accepted request runs the full register sequence on the divider: write divisor, write dividend (which starts the divider), poll ready, read quotient, read remainder. The results go back on a shared response bus.
- Divide-by-zero is answered locally without touching the divider.
- Sits between local compute clients and the divider's register port, in place of the bus.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 64, maximum POLL cycles before the operation is aborted.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  N_REQ  per-requester request pending; held until accepted
- req_dividend  in  32*N_REQ  flattened; slice i belongs to requester i; stable while req_valid
- req_divisor  in  32*N_REQ  flattened, as above
- req_ready  out  N_REQ  one-cycle acceptance pulse to the granted requester
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_id  out  $clog2(N_REQ)  requester index of the result
- resp_quotient  out  32
- resp_remainder  out  32
- resp_dbz  out  1  divisor was zero
- resp_timeout  out  1  divider never reported ready
- div_address  out  8  to divider address
- div_write_data  out  32
- div_we  out  1
- div_re  out  1
- div_read_data  in  32  combinational read data from divider

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state goes to IDLE and the round-robin pointer to N_REQ-1, so requester 0 has first priority.
  - All outputs are 0: req_ready, resp_*, div_we, div_re, div_address, div_write_data.
- Divider register map: 0x00 INFO (bit0 = ready), 0x04 divisor, 0x08 dividend plus start, 0x0C quotient, 0x10 remainder.
- Only registered outputs drive the divider port; writes are single-cycle.
- IDLE:
  - If any req_valid is set, grant g = first set bit searched from pointer+1 upward, wrapping.
  - Register g and move to GRANT. Arbitration happens only in IDLE.
- GRANT:
  - req_ready[g]=1 for exactly this cycle.
  - Latch the operands; pointer becomes g.
  - If the divisor is 0, go to RESP with quotient=0xFFFFFFFF, remainder=dividend, dbz=1. Otherwise go to WR_DIVISOR.
- WR_DIVISOR: address 0x04, we=1, write_data=divisor.
- WR_DIVIDEND: address 0x08, we=1, write_data=dividend; this starts the divider.
- WAIT: one idle cycle, because the divider's busy flag becomes visible only one cycle after the start write.
- POLL:
  - Drive address 0x00 with re=1 and sample div_read_data[0] each cycle.
  - If bit0 is 1, go to RD_QUO.
  - Otherwise increment the poll counter. When it equals TIMEOUT_CYCLES-1, go to RESP with timeout=1, quotient=0, remainder=0.
- RD_QUO: address 0x0C, re=1, capture quotient in the same cycle.
- RD_REM: address 0x10, re=1, capture remainder.
- RESP:
  - resp_valid=1 with stable id, data and flags.
  - On resp_valid & resp_ready, clear resp_valid and return to IDLE.
  - A new grant can be made no earlier than the cycle after the handshake.
- Latency, with the GRANT cycle counted as cycle 0:
  - For a divider with B busy cycles, resp_valid rises at cycle B+6. For seq_divider, B=33, giving cycle 39.
  - For dbz, resp_valid rises at cycle 1.
- The poll counter is cleared in GRANT. The dbz and timeout flags are mutually exclusive.
- Back-pressure: while resp_ready=0 the block holds in RESP; no requester sees req_ready.
- A requester that deasserts req_valid before acceptance is a protocol violation; the behaviour is not defined.
- Reset mid-operation: the block returns to IDLE immediately and the in-flight result is discarded. The divider keeps its own state. If a new operation arrives while the divider is still busy, POLL simply waits longer.
- Width rules: unsigned 32-bit; no sign handling.

Decomposition:
- Package div_ctrl_pkg holds:
  - the divider register offsets (INFO, DIVISOR, DIVIDEND, QUOTIENT, REMAINDER);
  - the state encoding (IDLE, GRANT, WR_DIVISOR, WR_DIVIDEND, WAIT, POLL, RD_QUO, RD_REM, RESP);
  - DBZ_QUOTIENT = 32'hFFFFFFFF.
- Sub-module rr_arbiter (parameter N_REQ) is purely combinational. Inputs: request vector and pointer. Outputs: one-hot grant and encoded index.

Test Plan:
- Single divide: req 0 with 100 / 7, seq_divider-compatible model with B=33 -> exactly one req_ready[0] pulse. Divider bus shows a write of 7 to 0x04, then a write of 100 to 0x08. resp_valid at cycle 39 with id=0, q=14, r=2, dbz=0, timeout=0.
- Divide by zero: req 2 with 55 / 0 -> resp at cycle 1 with id=2, q=0xFFFFFFFF, r=55, dbz=1. Zero div_we/div_re activity.
- Round-robin: all four requesters valid continuously, resp_ready=1 -> grant order 0,1,2,3,0. No requester is granted twice before the others are served.
- Back-pressure: hold resp_ready=0 for 10 cycles during RESP -> resp fields stable, no new req_ready. Release gives a one-cycle handshake, then the next grant.
- Timeout: divider model never sets ready -> resp_timeout=1 with q=0, r=0 after TIMEOUT_CYCLES POLL cycles. The block then returns to IDLE and serves the next request.
- Reset mid-POLL: assert rst for 1 cycle -> next cycle all outputs are 0 and state is IDLE. A subsequent 0xFFFFFFFF / 16 completes with q=0x0FFFFFFF, r=15.
